// File: rtl/player_pkg.sv
// Shared encodings for the music player control slice.
package player_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED    = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_RESETTING = 2'd2
  } state_t;

  localparam logic [1:0] MODE_STOP         = 2'd0;
  localparam logic [1:0] MODE_REPEAT       = 2'd1;
  localparam logic [1:0] MODE_ADVANCE      = 2'd2;
  localparam logic [1:0] MODE_ADVANCE_ONCE = 2'd3;

endpackage

// File: rtl/song_index_counter.sv
// Up/down modulo-NUM_SONGS song index counter; inc wins over dec.
module song_index_counter #(
  parameter int NUM_SONGS = 4,
  parameter int SONG_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [SONG_W-1:0] count,
  output logic              last,
  output logic              first
);

  localparam logic [SONG_W-1:0] LAST_IDX = SONG_W'(NUM_SONGS - 1);

  assign last  = (count == LAST_IDX);
  assign first = (count == '0);

  // Step the index with explicit wrap so non-power-of-two counts stay in range.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + 1'b1;
    end else if (dec) begin
      count <= first ? LAST_IDX : count - 1'b1;
    end
  end

endmodule

// File: rtl/playback_controller.sv
// Master play/pause/song-select sequencer for song_reader with end-of-song policy.
module playback_controller
  import player_pkg::*;
#(
  parameter int NUM_SONGS = 4,
  parameter int SONG_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic [1:0]        loop_mode,
  input  logic              song_done,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song
);

  state_t state, state_nxt;
  logic   resume_q, resume_nxt;
  logic   inc, dec;
  logic   song_last, song_first;

  song_index_counter #(
    .NUM_SONGS (NUM_SONGS),
    .SONG_W    (SONG_W)
  ) u_song_index_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .dec   (dec),
    .count (song),
    .last  (song_last),
    .first (song_first)
  );

  // Decode at most one event per cycle by priority; RESETTING drops everything.
  always_comb begin
    state_nxt  = state;
    resume_nxt = resume_q;
    inc        = 1'b0;
    dec        = 1'b0;
    case (state)
      ST_PAUSED, ST_PLAYING: begin
        if (next_button) begin
          inc        = 1'b1;
          state_nxt  = ST_RESETTING;
          resume_nxt = (state == ST_PLAYING);
        end else if (prev_button) begin
          dec        = 1'b1;
          state_nxt  = ST_RESETTING;
          resume_nxt = (state == ST_PLAYING);
        end else if (song_done && state == ST_PLAYING) begin
          state_nxt = ST_RESETTING;
          case (loop_mode)
            MODE_STOP:         resume_nxt = 1'b0;
            MODE_REPEAT:       resume_nxt = 1'b1;
            MODE_ADVANCE: begin
              inc        = 1'b1;
              resume_nxt = 1'b1;
            end
            default: begin
              inc        = 1'b1;
              resume_nxt = !song_last;
            end
          endcase
        end else if (play_button) begin
          state_nxt = (state == ST_PLAYING) ? ST_PAUSED : ST_PLAYING;
        end
      end
      ST_RESETTING: state_nxt = resume_q ? ST_PLAYING : ST_PAUSED;
      default:      state_nxt = ST_PAUSED;
    endcase
  end

  // State, resume flag and outputs registered together from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_PAUSED;
      resume_q     <= 1'b0;
      play         <= 1'b0;
      reset_player <= 1'b0;
    end else begin
      state        <= state_nxt;
      resume_q     <= resume_nxt;
      play         <= (state_nxt == ST_PLAYING);
      reset_player <= (state_nxt == ST_RESETTING);
    end
  end

  logic unused_first;
  assign unused_first = song_first;

endmodule
